// File: rtl/seven_seg_scanner_pkg.sv
// Shared constants and types for the seven-segment display path (package seg_pkg).
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned SEG_W      = 8;

    typedef logic [SEG_W-1:0] seg_pattern_t;

    localparam seg_pattern_t SEG_BLANK = 8'hFF;

    localparam logic [NUM_DIGITS-1:0] AN_OFF = '1;

    // Active-low anode for each digit index; index 0 is the rightmost digit.
    localparam logic [NUM_DIGITS-1:0] AN_LUT [NUM_DIGITS] = '{
        4'b1110, 4'b1101, 4'b1011, 4'b0111
    };

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Pattern/blink inputs and multiplexed pin outputs of the seven-segment scanner.
interface seven_seg_scanner_if;
    import seg_pkg::*;

    seg_pattern_t          digit0_display;
    seg_pattern_t          digit1_display;
    seg_pattern_t          digit2_display;
    seg_pattern_t          digit3_display;
    logic [NUM_DIGITS-1:0] blink_en;
    logic                  blink_toggle;
    seg_pattern_t          seg;
    logic [NUM_DIGITS-1:0] an;
    logic                  frame_start;

    modport master (
        output digit0_display, digit1_display, digit2_display, digit3_display,
        output blink_en, blink_toggle,
        input  seg, an, frame_start
    );

    modport slave (
        input  digit0_display, digit1_display, digit2_display, digit3_display,
        input  blink_en, blink_toggle,
        output seg, an, frame_start
    );

endinterface

// File: rtl/seven_seg_scanner_refresh_divider.sv
// Free-running slot counter; tick_c is high on the last cycle of every REFRESH_DIV-cycle period.
module refresh_divider #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic                           clk,
    input  logic                           rst_n,
    output logic [$clog2(REFRESH_DIV)-1:0] cnt,
    output logic                           tick_c
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick_c = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        cnt_d  = tick_c ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seven_seg_scanner.sv
// Four-digit time-multiplexed seven-segment driver with frame-synchronous shadowing and blink.
// Optional anode blanking at the start of each slot is enabled with `define SEG_GHOST_BLANK_EN.
module seven_seg_scanner
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned GHOST_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    seven_seg_scanner_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    logic [CNT_W-1:0]      cnt;
    logic                  tick_c;

    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  blink_phase_q, blink_phase_d;
    seg_pattern_t          shadow_q [NUM_DIGITS];
    seg_pattern_t          shadow_d [NUM_DIGITS];
    seg_pattern_t          seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  frame_start_q, frame_start_d;
    logic                  reload_c;
    logic                  blink_blank_c;

    refresh_divider #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_refresh_divider (
        .clk    (clk),
        .rst_n  (rst_n),
        .cnt    (cnt),
        .tick_c (tick_c)
    );

`ifndef SEG_GHOST_BLANK_EN
    logic unused_ghost;
    assign unused_ghost = ^{32'(GHOST_CYCLES), cnt};
`endif

    always_comb begin
        idx_d         = idx_q;
        blink_phase_d = blink_phase_q;
        shadow_d      = shadow_q;
        frame_start_d = 1'b0;
        reload_c      = 1'b0;
        blink_blank_c = 1'b0;
        seg_d         = SEG_BLANK;
        an_d          = AN_OFF;

        if (tick_c) begin
            idx_d = idx_q + IDX_W'(1);
        end

        // A whole frame reloads only as the last digit slot ends, so a count never tears.
        reload_c = tick_c && (idx_q == IDX_W'(NUM_DIGITS - 1));
        if (reload_c) begin
            shadow_d[0]   = bus.digit0_display;
            shadow_d[1]   = bus.digit1_display;
            shadow_d[2]   = bus.digit2_display;
            shadow_d[3]   = bus.digit3_display;
            frame_start_d = 1'b1;
        end

        if (bus.blink_toggle) begin
            blink_phase_d = ~blink_phase_q;
        end

        blink_blank_c = blink_phase_q && bus.blink_en[idx_q];
        an_d          = AN_LUT[idx_q];
        seg_d         = blink_blank_c ? SEG_BLANK : shadow_q[idx_q];

`ifdef SEG_GHOST_BLANK_EN
        if (cnt < CNT_W'(GHOST_CYCLES)) begin
            an_d  = AN_OFF;
            seg_d = SEG_BLANK;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q         <= '0;
            blink_phase_q <= 1'b0;
            shadow_q      <= '{default: SEG_BLANK};
            seg_q         <= SEG_BLANK;
            an_q          <= AN_OFF;
            frame_start_q <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            blink_phase_q <= blink_phase_d;
            shadow_q      <= shadow_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign bus.seg         = seg_q;
    assign bus.an          = an_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with REFRESH_DIV=4, GHOST_CYCLES=1.
module tb_seven_seg_scanner;

    localparam int unsigned REFRESH_DIV  = 4;
    localparam int unsigned GHOST_CYCLES = 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   passes = 0;
    int   fails  = 0;
    int   total  = 0;

    logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    logic [7:0] pat    [4] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0};

    seven_seg_scanner_if bus ();

    seven_seg_scanner #(
        .REFRESH_DIV  (REFRESH_DIV),
        .GHOST_CYCLES (GHOST_CYCLES)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock and check the outputs registered at that edge (k = cycles since reset release).
    task automatic cycle(input int k, input logic [7:0] exp_seg, input logic exp_fs);
        logic       ghost;
        logic [3:0] exp_an;
        logic [7:0] exp_sg;
        @(posedge clk);
        @(negedge clk);
        ghost = 1'b0;
`ifdef SEG_GHOST_BLANK_EN
        ghost = (k % 4 == 0);
`endif
        exp_an = ghost ? 4'b1111 : an_tab[(k / 4) % 4];
        exp_sg = ghost ? 8'hFF : exp_seg;
        chk($sformatf("an k=%0d", k), {4'h0, bus.an}, {4'h0, exp_an});
        chk($sformatf("seg k=%0d", k), bus.seg, exp_sg);
        chk($sformatf("frame_start k=%0d", k), {7'h0, bus.frame_start}, {7'h0, exp_fs});
    endtask

    initial begin
        int         slot;
        logic [7:0] exp_s;

        bus.digit0_display = 8'hC0;
        bus.digit1_display = 8'hF9;
        bus.digit2_display = 8'hA4;
        bus.digit3_display = 8'hB0;
        bus.blink_en       = 4'b0000;
        bus.blink_toggle   = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset an", {4'h0, bus.an}, 8'h0F);
        chk("reset seg", bus.seg, 8'hFF);
        chk("reset frame_start", {7'h0, bus.frame_start}, 8'h00);
        rst_n = 1'b1;

        // Blank first frame: shadow still holds reset values.
        for (int k = 0; k < 16; k++) cycle(k, 8'hFF, k == 15);

        // Frames 1..4: patterns, mid-frame change of digit1, blink on/off of digit2.
        for (int k = 16; k < 80; k++) begin
            if (k == 32) pat[1] = 8'h99;
            slot  = (k / 4) % 4;
            exp_s = pat[slot];
            if (k >= 48 && k < 64 && slot == 2) exp_s = 8'hFF;
            cycle(k, exp_s, (k % 16) == 15);
            if (k == 17) bus.digit1_display = 8'h99;
            if (k == 47) begin
                bus.blink_en     = 4'b0100;
                bus.blink_toggle = 1'b1;
            end
            if (k == 48) bus.blink_toggle = 1'b0;
            if (k == 63) bus.blink_toggle = 1'b1;
            if (k == 64) bus.blink_toggle = 1'b0;
        end

        // Into the digit1 slot, then reset mid-slot.
        for (int k = 80; k < 86; k++) begin
            slot = (k / 4) % 4;
            cycle(k, pat[slot], 1'b0);
        end
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midreset an", {4'h0, bus.an}, 8'h0F);
        chk("midreset seg", bus.seg, 8'hFF);
        chk("midreset frame_start", {7'h0, bus.frame_start}, 8'h00);
        rst_n = 1'b1;

        // Scan restarts at digit 0 with a blank frame; blink phase is back to 0.
        for (int k = 0; k < 16; k++) cycle(k, 8'hFF, k == 15);
        for (int k = 16; k < 32; k++) begin
            slot = (k / 4) % 4;
            cycle(k, pat[slot], (k % 16) == 15);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
